// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM client arbiter
package sdram_arb_pkg;

    localparam int NPORTS = 3;

    typedef logic [1:0] port_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        REST
    } arb_state_t;

    function automatic port_idx_t next_idx(input port_idx_t i);
        return (i == port_idx_t'(NPORTS - 1)) ? '0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// rtl/sdram_arb_pick.sv - grant selector: fixed 0>1>2, or round-robin when SDRAM_ARB_RR_EN is defined
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
`ifdef SDRAM_ARB_RR_EN
    input  logic              clk,
    input  logic              rst,
    input  logic              advance_i,
`endif
    input  logic [NPORTS-1:0] req_i,
    output logic              valid_o,
    output port_idx_t         idx_o
);

`ifdef SDRAM_ARB_RR_EN
    port_idx_t ptr_q;
    port_idx_t ptr_d;
    port_idx_t cand;

    // ptr_q holds the last granted port; the search starts just after it
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = ptr_q;
        for (int i = 0; i < NPORTS; i++) begin
            cand = next_idx(cand);
            if (!valid_o && req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = cand;
            end
        end
        ptr_d = advance_i ? idx_o : ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        valid_o = |req_i;
        idx_o   = req_i[0] ? 2'd0 : (req_i[1] ? 2'd1 : 2'd2);
    end
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - three-client arbiter in front of the SDRAM controller; SDRAM_ARB_RR_EN selects round-robin
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int GUARD  = 2
) (
    input  logic              clk,
    input  logic              init,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [15:0]       p0_din,
    input  logic [1:0]        p0_wtbt,
    output logic [15:0]       p0_dout,
    output logic              p0_ack,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [15:0]       p1_din,
    input  logic [1:0]        p1_wtbt,
    output logic [15:0]       p1_dout,
    output logic              p1_ack,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [15:0]       p2_din,
    input  logic [1:0]        p2_wtbt,
    output logic [15:0]       p2_dout,
    output logic              p2_ack,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [15:0]       sd_din,
    output logic [1:0]        sd_wtbt,
    output logic              sd_we,
    output logic              sd_rd,
    input  logic [15:0]       sd_dout,
    input  logic              sd_ready
);

    localparam int GW = $clog2(GUARD + 1);

    arb_state_t        state_q;
    logic [GW-1:0]     g_q;
    port_idx_t         gnt_q;
    logic [NPORTS-1:0] ack_q;
    logic [15:0]       dout_q [NPORTS];

    logic [NPORTS-1:0] req;
    logic [NPORTS-1:0] we;
    logic [ADDR_W-1:0] addr [NPORTS];
    logic [15:0]       din  [NPORTS];
    logic [1:0]        wtbt [NPORTS];
    logic              pick_valid;
    port_idx_t         pick_idx;
    logic              grant;

    assign req     = {p2_req, p1_req, p0_req};
    assign we      = {p2_we, p1_we, p0_we};
    assign addr[0] = p0_addr;
    assign addr[1] = p1_addr;
    assign addr[2] = p2_addr;
    assign din[0]  = p0_din;
    assign din[1]  = p1_din;
    assign din[2]  = p2_din;
    assign wtbt[0] = p0_wtbt;
    assign wtbt[1] = p1_wtbt;
    assign wtbt[2] = p2_wtbt;

    assign grant = (state_q == IDLE) && sd_ready && pick_valid;

    sdram_arb_pick u_pick (
`ifdef SDRAM_ARB_RR_EN
        .clk       (clk),
        .rst       (init),
        .advance_i (grant),
`endif
        .req_i     (req),
        .valid_o   (pick_valid),
        .idx_o     (pick_idx)
    );

    // Strobe stays up through ISSUE so ready is only trusted once the controller has seen the edge
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q <= IDLE;
            g_q     <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            sd_addr <= '0;
            sd_din  <= '0;
            sd_wtbt <= '0;
            sd_we   <= 1'b0;
            sd_rd   <= 1'b0;
            for (int i = 0; i < NPORTS; i++) begin
                dout_q[i] <= '0;
            end
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        gnt_q   <= pick_idx;
                        sd_addr <= addr[pick_idx];
                        sd_din  <= din[pick_idx];
                        sd_wtbt <= wtbt[pick_idx];
                        sd_we   <= we[pick_idx];
                        sd_rd   <= ~we[pick_idx];
                        g_q     <= '0;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (g_q == GW'(GUARD)) begin
                        state_q <= WAIT;
                    end else begin
                        g_q <= g_q + GW'(1);
                    end
                end
                WAIT: begin
                    if (sd_ready) begin
                        ack_q[gnt_q] <= 1'b1;
                        if (sd_rd) begin
                            dout_q[gnt_q] <= sd_dout;
                        end
                        sd_rd   <= 1'b0;
                        sd_we   <= 1'b0;
                        state_q <= REST;
                    end
                end
                REST: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p0_dout = dout_q[0];
    assign p1_dout = dout_q[1];
    assign p2_dout = dout_q[2];
    assign p0_ack  = ack_q[0];
    assign p1_ack  = ack_q[1];
    assign p2_ack  = ack_q[2];

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Three-client arbiter sitting directly upstream of the single-port SDRAM controller.
- Serialises client requests onto the controller's edge-triggered rd/we + ready interface.
- Returns read data and a one-cycle ack to each client.
- Intended clients: 68k main CPU (port 0), Z80 (port 1), VDP DMA (port 2). All share clk with the controller.

Parameters:
- ADDR_W, 25, byte address width; bit 0 is significant only in 8-bit write mode.
- GUARD, 2, cycles after raising sd_rd/sd_we before sd_ready is sampled; must be ≥2.

Ports:
- clk  in  1  system clock (~100MHz, same as controller)
- init  in  1  reset, asynchronous, active-high
- pN_req  in  1  (N=0..2) request; held high with fields stable until pN_ack
- pN_we  in  1  1=write, 0=read
- pN_addr  in  ADDR_W  byte address
- pN_din  in  16  write data
- pN_wtbt  in  2  byte-enable code, passed through unchanged to controller
- pN_dout  out  16  read data, held until that port's next read ack
- pN_ack  out  1  one-cycle completion pulse
- sd_addr  out  ADDR_W  to controller addr
- sd_din  out  16  to controller din
- sd_wtbt  out  2  to controller wtbt
- sd_we  out  1  controller write strobe; rising edge starts a write
- sd_rd  out  1  controller read strobe; rising edge starts a read
- sd_dout  in  16  controller dout
- sd_ready  in  1  controller ready

Behaviour:
- Reset (async, init=1): state=IDLE; all outputs 0; grant pointer=0; no pending request.
- States:
  - IDLE: wait for sd_ready=1. Covers controller startup, where ready stays low ~12100 cycles; nothing issues until then.
  - IDLE → ISSUE when any req is high and sd_ready=1. Select port by fixed priority 0>1>2, or round-robin (see Optional Feature). Register the granted port's addr/din/wtbt onto sd_*.
  - ISSUE: drive sd_rd=~we or sd_we=we high for exactly this cycle and the GUARD cycles that follow, counted by guard counter g. → WAIT after GUARD cycles.
  - WAIT: hold the strobe high. When sd_ready=1:
    - capture sd_dout into the granted port's dout (reads only);
    - pulse that port's ack;
    - drop the strobe;
    - → REST.
  - REST: one cycle with both strobes low, so the next request produces a clean rising edge. → IDLE.
- Same-word read hit: the controller may never drop ready, because it short-circuits reads to the same 16-bit word. The GUARD wait makes that case safe: ready=1 sampled in WAIT is a valid completion.
- Minimum latency, request to ack: 1 (IDLE) + 1+GUARD (ISSUE) + 1 (WAIT) = 5 cycles with GUARD=2. Read miss and write latency is set by the controller.
- Back-to-back transactions from the same port: the port must drop req the cycle after ack. Re-asserting req in that cycle is ignored until REST completes.
- A request withdrawn before grant is simply not served. A request withdrawn after grant is a protocol violation: the transaction still completes and ack still pulses.
- Simultaneous requests: exactly one grant per IDLE→ISSUE transition. Losing ports wait with their fields held.
- Never raises sd_rd and sd_we together.
- init asserted mid-transaction: strobes drop immediately; no ack is issued; pN_dout clears to 0.

Optional Feature:
- Macro SDRAM_ARB_RR_EN.
- Defined: round-robin. After a grant to port k, search order is k+1, k+2, k. Resets to pointer 0.
- Undefined: fixed priority 0>1>2; no pointer register exists.

Decomposition:
- Package sdram_arb_pkg holds:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, REST};
  - NPORTS=3;
  - a port-index type.
- Sub-module sdram_arb_pick: combinational/registered grant selector (fixed or RR).

Test Plan:
- Startup gating: hold sd_ready=0 for 200 cycles with p0_req=1 → sd_rd stays 0. Raise sd_ready → sd_rd rises the cycle after.
- Read miss: p1 read addr 0x000124. Model drops ready 1 cycle after the sd_rd edge and returns 0xBEEF 6 cycles later → p1_dout=0xBEEF, one p1_ack pulse, sd_rd low for ≥1 cycle.
- Same-word hit: p0 read 0x000100, then p0 read 0x000101 with the model keeping ready=1 → ack 5 cycles after req, dout = model's swapped data.
- Contention: p0, p1 and p2 request in the same cycle, each with a write of din=0x1111/0x2222/0x3333.
  - Fixed priority: order 0,1,2.
  - With SDRAM_ARB_RR_EN and prior grant=0: order 1,2,0.
  - sd_we never overlaps sd_rd.
- Write passthrough: p2 write, wtbt=2'b10, din=0xA55A, addr 0x1FFFFFE → sd_* carry exactly these values; ack after ready returns.
- Async reset mid-WAIT: assert init between clock edges → sd_rd=0 immediately, no ack, state IDLE after release.
